dijkstra_mem_read_master: RTL and testbench
===========================================

Name: dijkstra_mem_read_master

Overview:
Memory-side read stage that sits directly downstream of the Dijkstra algorithm interface. It accepts single-word read requests on the algorithm's mem_read_enable/mem_addr handshake and translates them into Avalon-MM master reads (waitrequest plus variable-latency readdatavalid). It returns the read data with a one-cycle mem_read_ready pulse and flags bus timeouts. One outstanding read at a time; requests arriving while busy are queued in a single-entry skid register.

Parameters:
ADDR_W, 32, width of request and Avalon addresses
DATA_W, 32, width of Avalon readdata and returned data
TIMEOUT, 255, maximum algorithm_clock cycles from avm_read acceptance to readdatavalid before error
TO_W, 8, width of timeout counter (must hold TIMEOUT)

Ports:
algorithm_clock  input  1  clock for all logic
algorithm_reset  input  1  asynchronous, active-high reset
base_address  input  ADDR_W  byte base of the graph table; sampled at request accept
mem_read_enable  input  1  request strobe from algorithm; one cycle = one read
mem_addr  input  ADDR_W  word index of request, relative to base_address
wait_request  output  1  high = request skid full; upstream must hold off
mem_read_data  output  DATA_W  returned word, valid while mem_read_ready=1
mem_read_ready  output  1  one-cycle pulse per completed read
rd_error  output  1  sticky timeout flag; cleared only by reset
avm_address  output  ADDR_W  Avalon byte address
avm_read  output  1  Avalon read strobe
avm_waitrequest  input  1  Avalon stall
avm_readdata  input  DATA_W  Avalon read data
avm_readdatavalid  input  1  Avalon data-valid

Behaviour:
- Reset (async, algorithm_reset=1): state=IDLE; avm_read=0, avm_address=0, mem_read_ready=0, mem_read_data=0, wait_request=0, rd_error=0, skid empty, timeout counter=0.
- Address: avm_address = base_address + (mem_addr << 2), computed at accept, truncated to ADDR_W (wrap, no error).
- Accept: a mem_read_enable cycle with wait_request=0 is accepted. If state=IDLE and skid is empty, the request goes straight to ISSUE on the next edge. Otherwise it is stored in the skid. mem_read_enable while wait_request=1 is dropped. Upstream must not do this.
- wait_request = skid full (registered). It asserts the cycle after the skid fills and deasserts the cycle after the skid drains into ISSUE.
- FSM:
  - IDLE: avm_read=0. On accept, or if the skid is valid, load avm_address and go to ISSUE. The skid takes priority over a new request. A simultaneous new request is stored in the skid.
  - ISSUE: avm_read=1, address held stable. If avm_waitrequest=0, the read is accepted at that edge: go to WAIT_DATA and clear the timeout counter. If avm_waitrequest=1, stay in ISSUE. Waitrequest duration is unbounded and does not count toward the timeout.
  - WAIT_DATA: avm_read=0. On avm_readdatavalid: register mem_read_data=avm_readdata, pulse mem_read_ready for exactly 1 cycle, go to IDLE. Otherwise increment the counter. On reaching TIMEOUT: set rd_error, pulse mem_read_ready with mem_read_data=all-ones, go to IDLE.
- Latency: minimum 3 cycles from mem_read_enable to mem_read_ready, with avm_waitrequest=0 and readdatavalid in the first WAIT_DATA cycle.
- Back-to-back: from IDLE with a valid skid, ISSUE is entered on the cycle after the mem_read_ready pulse. There is no bubble beyond IDLE.
- readdatavalid in IDLE or ISSUE (spurious or late after timeout) is ignored and does not pulse mem_read_ready.
- Reset mid-read: everything returns immediately to reset values. The in-flight Avalon response is discarded per the rule above.
- Exactly one mem_read_ready pulse per accepted request, in request order.

Test Plan:
- base_address=0x10, mem_addr=5, avm_waitrequest=0, readdatavalid 1 cycle after accept, readdata=0x0000ABCD -> avm_address=0x24; mem_read_ready pulses once, 3 cycles after request, with mem_read_data=0x0000ABCD; rd_error=0.
- avm_waitrequest held high 4 cycles during ISSUE -> avm_read and avm_address stay stable for 5 cycles; one read accepted; no timeout even with TIMEOUT=2.
- Two requests (mem_addr=1, then 2) on consecutive cycles while the first is in WAIT_DATA -> wait_request=1 after the second; two mem_read_ready pulses in order with data for addresses 0x14 then 0x18; wait_request returns to 0.
- TIMEOUT=8, readdatavalid never asserted -> mem_read_ready pulses 9 cycles after read acceptance with data=0xFFFFFFFF; rd_error=1 and remains 1 through later successful reads.
- algorithm_reset asserted while in WAIT_DATA, then readdatavalid arrives -> all outputs 0 immediately; no mem_read_ready pulse; the next request completes normally.
- base_address=0xFFFFFFF0, mem_addr=8 -> avm_address=0x00000010 (wrap); read completes normally.

Source files
------------

// File: rtl/dijkstra_mem_read_master.sv
// dijkstra_mem_read_master
// Turns single-word read requests from the Dijkstra core into Avalon-MM
// master reads. One read is in flight at a time; a single skid entry holds
// one further request while the bus side is busy. A read that gets no
// readdatavalid within TIMEOUT cycles is completed with all-ones data and
// sets a sticky error flag.
module dijkstra_mem_read_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              algorithm_clock,
  input  logic              algorithm_reset,
  input  logic [ADDR_W-1:0] base_address,
  input  logic              mem_read_enable,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic              wait_request,
  output logic [DATA_W-1:0] mem_read_data,
  output logic              mem_read_ready,
  output logic              rd_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DATA = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_avm_address;
  logic [ADDR_W-1:0] w_avm_address_next;
  logic              r_skid_valid;
  logic              w_skid_valid_next;
  logic [ADDR_W-1:0] r_skid_addr;
  logic [ADDR_W-1:0] w_skid_addr_next;
  logic [TO_W-1:0]   r_cnt;
  logic [TO_W-1:0]   w_cnt_next;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_next;
  logic              r_ready;
  logic              w_ready_next;
  logic              r_error;
  logic              w_error_next;
  logic              w_avm_read;
  logic              w_accept;
  logic [ADDR_W-1:0] w_req_addr;

  // A request is only taken while the skid has room; wait_request is the
  // registered skid-full flag, so upstream sees it one cycle after filling.
  assign w_accept   = mem_read_enable & ~r_skid_valid;
  // Word index to byte address; overflow simply wraps.
  assign w_req_addr = base_address + (mem_addr << 2);

  // Next-state and output decode for the bus FSM and its datapath.
  always_comb begin
    w_state_next       = r_state;
    w_avm_address_next = r_avm_address;
    w_skid_valid_next  = r_skid_valid;
    w_skid_addr_next   = r_skid_addr;
    w_cnt_next         = r_cnt;
    w_data_next        = r_data;
    w_ready_next       = 1'b0;
    w_error_next       = r_error;
    w_avm_read         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_skid_valid) begin
          // Older queued request goes first.
          w_avm_address_next = r_skid_addr;
          w_skid_valid_next  = 1'b0;
          w_state_next       = S_ISSUE;
        end else if (w_accept) begin
          w_avm_address_next = w_req_addr;
          w_state_next       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_avm_read = 1'b1;
        // Stall cycles are not timed; the clock starts at bus acceptance.
        if (!avm_waitrequest) begin
          w_cnt_next   = '0;
          w_state_next = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (avm_readdatavalid) begin
          w_data_next  = avm_readdata;
          w_ready_next = 1'b1;
          w_state_next = S_IDLE;
        end else if (r_cnt == TO_W'(TIMEOUT)) begin
          w_data_next  = '1;
          w_ready_next = 1'b1;
          w_error_next = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + TO_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Anything accepted that did not go straight to ISSUE lands in the skid.
    if (w_accept && (r_state != S_IDLE || r_skid_valid)) begin
      w_skid_valid_next = 1'b1;
      w_skid_addr_next  = w_req_addr;
    end
  end

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge algorithm_clock or posedge algorithm_reset) begin
    if (algorithm_reset) begin
      r_state       <= S_IDLE;
      r_avm_address <= '0;
      r_skid_valid  <= 1'b0;
      r_skid_addr   <= '0;
      r_cnt         <= '0;
      r_data        <= '0;
      r_ready       <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_avm_address <= w_avm_address_next;
      r_skid_valid  <= w_skid_valid_next;
      r_skid_addr   <= w_skid_addr_next;
      r_cnt         <= w_cnt_next;
      r_data        <= w_data_next;
      r_ready       <= w_ready_next;
      r_error       <= w_error_next;
    end
  end

  assign wait_request   = r_skid_valid;
  assign mem_read_data  = r_data;
  assign mem_read_ready = r_ready;
  assign rd_error       = r_error;
  assign avm_address    = r_avm_address;
  assign avm_read       = w_avm_read;

endmodule

// File: tb/tb_dijkstra_mem_read_master.sv
// Bench for dijkstra_mem_read_master: directed scenarios followed by random
// traffic against an Avalon slave model, with a scoreboard of expected
// addresses and read responses.
module tb_dijkstra_mem_read_master;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TMO    = 8;
  localparam int TO_W   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] base_address = '0;
  logic              mem_read_enable = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic              wait_request;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_read_ready;
  logic              rd_error;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_waitrequest = 1'b0;
  logic [DATA_W-1:0] avm_readdata = '0;
  logic              avm_readdatavalid = 1'b0;

  dijkstra_mem_read_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO), .TO_W(TO_W)
  ) dut (
    .algorithm_clock  (clk),
    .algorithm_reset  (rst),
    .base_address     (base_address),
    .mem_read_enable  (mem_read_enable),
    .mem_addr         (mem_addr),
    .wait_request     (wait_request),
    .mem_read_data    (mem_read_data),
    .mem_read_ready   (mem_read_ready),
    .rd_error         (rd_error),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
    bit                to;
  } resp_t;

  logic [ADDR_W-1:0] addr_q[$];
  resp_t             resp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_req = 0;
  int n_done = 0;
  int last_ready_cyc = 0;
  bit model_err = 1'b0;

  // slave model controls
  bit                rnd_mode = 1'b0;
  bit                spur_en  = 1'b0;
  int                dir_k    = 1;
  int                stall_left = 0;
  bit                s_out = 1'b0;
  int                s_cyc = 0;
  int                s_k   = 0;
  logic [DATA_W-1:0] s_data = '0;
  bit                prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Avalon slave: stalls, accepts reads, answers after k cycles (k=0: never).
  initial begin
    forever begin
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      if (s_out) begin
        s_cyc++;
        if (s_k != 0 && s_cyc == s_k) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = s_data;
          s_out             = 1'b0;
        end else if (s_k == 0 && s_cyc == TMO + 1) begin
          s_out = 1'b0;
        end
      end else if (spur_en && $urandom_range(0, 9) == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = $urandom;
      end

      if (prev_stall) begin
        check("issue_hold_read", {63'd0, avm_read}, 64'd1);
        check("issue_hold_addr", {32'd0, avm_address}, {32'd0, prev_addr});
      end

      if (rnd_mode && stall_left == 0 && $urandom_range(0, 3) == 0)
        stall_left = $urandom_range(1, 6);
      avm_waitrequest = (stall_left > 0);
      if (avm_read && stall_left > 0) stall_left--;
      prev_stall = avm_read && avm_waitrequest && !rst;
      prev_addr  = avm_address;

      if (avm_read && !avm_waitrequest && !rst) begin
        resp_t r;
        int    k;
        if (addr_q.size() == 0) check("avm_read_unexpected", 64'd1, 64'd0);
        else check("avm_address", {32'd0, avm_address}, {32'd0, addr_q.pop_front()});
        if (rnd_mode) k = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, TMO));
        else k = dir_k;
        s_out  = 1'b1;
        s_cyc  = 0;
        s_k    = k;
        s_data = $urandom;
        r.to   = (k == 0);
        r.data = r.to ? '1 : s_data;
        // acceptance edge is cyc+1; completion visible k (or TMO+1) cycles later
        r.due  = cyc + 1 + (r.to ? TMO + 1 : k);
        resp_q.push_back(r);
      end
    end
  end

  // Monitor: every ready pulse must match the oldest expected response.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_read_ready) begin
        if (resp_q.size() == 0) begin
          check("ready_unexpected", 64'd1, 64'd0);
        end else begin
          resp_t r;
          r = resp_q.pop_front();
          if (r.to) model_err = 1'b1;
          check("rd_data", {32'd0, mem_read_data}, {32'd0, r.data});
          check("rd_latency", 64'(cyc), 64'(r.due));
          check("rd_error", {63'd0, rd_error}, {63'd0, model_err});
          n_done++;
          last_ready_cyc = cyc;
          $display("read %0d: data=%08h timeout=%0d err=%0d cycle=%0d",
                   n_done, mem_read_data, r.to, rd_error, cyc);
        end
      end
    end
  end

  // Drive one request at the current negedge (waiting out wait_request first).
  task automatic req(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] a, output int t);
    int n;
    n = 0;
    while (wait_request && n < 200) begin
      mem_read_enable = 1'b0;
      @(negedge clk);
      n++;
    end
    check("req_wait_bound", {63'd0, wait_request}, 64'd0);
    base_address    = b;
    mem_addr        = a;
    mem_read_enable = 1'b1;
    addr_q.push_back(b + (a * 4));
    n_req++;
    t = cyc;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((addr_q.size() != 0 || resp_q.size() != 0 || s_out) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_bound", {63'd0, (n >= 3000)}, 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t0;
    int p;
    repeat (3) @(negedge clk);
    check("rst_avm_read", {63'd0, avm_read}, 64'd0);
    check("rst_avm_address", {32'd0, avm_address}, 64'd0);
    check("rst_ready", {63'd0, mem_read_ready}, 64'd0);
    check("rst_data", {32'd0, mem_read_data}, 64'd0);
    check("rst_wait_request", {63'd0, wait_request}, 64'd0);
    check("rst_error", {63'd0, rd_error}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // single read, minimum latency
    dir_k = 1;
    req(32'h10, 32'd5, t0);
    mem_read_enable = 1'b0;
    drain();
    check("min_latency", 64'(last_ready_cyc - t0), 64'd3);

    // 4-cycle bus stall followed by the slowest in-window response
    stall_left = 4;
    dir_k = TMO;
    req(32'h100, 32'd3, t0);
    mem_read_enable = 1'b0;
    drain();

    // two back-to-back requests fill the skid
    dir_k = 1;
    req(32'h10, 32'd1, t0);
    req(32'h10, 32'd2, t0);
    mem_read_enable = 1'b0;
    check("skid_wait_request", {63'd0, wait_request}, 64'd1);
    drain();
    check("skid_released", {63'd0, wait_request}, 64'd0);

    // timeout, then a good read with the error still set
    dir_k = 0;
    req(32'h0, 32'd7, t0);
    mem_read_enable = 1'b0;
    drain();
    dir_k = 2;
    req(32'h40, 32'd1, t0);
    mem_read_enable = 1'b0;
    drain();
    check("error_sticky", {63'd0, rd_error}, 64'd1);

    // reset while a read is waiting for data
    dir_k = 5;
    req(32'h200, 32'd4, t0);
    mem_read_enable = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_avm_read", {63'd0, avm_read}, 64'd0);
    check("midrst_avm_address", {32'd0, avm_address}, 64'd0);
    check("midrst_ready", {63'd0, mem_read_ready}, 64'd0);
    check("midrst_data", {32'd0, mem_read_data}, 64'd0);
    check("midrst_wait_request", {63'd0, wait_request}, 64'd0);
    check("midrst_error", {63'd0, rd_error}, 64'd0);
    n_req -= addr_q.size() + resp_q.size();
    addr_q.delete();
    resp_q.delete();
    model_err = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    drain();
    dir_k = 1;
    req(32'h300, 32'd9, t0);
    mem_read_enable = 1'b0;
    drain();

    // address wrap
    req(32'hFFFF_FFF0, 32'd8, t0);
    mem_read_enable = 1'b0;
    drain();

    // random traffic: stalls, timeouts, spurious valids, light and heavy load
    rnd_mode = 1'b1;
    spur_en  = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      p = ((i / 500) % 2 == 0) ? 30 : 90;
      if (!wait_request && $urandom_range(0, 99) < p) begin
        base_address    = $urandom;
        mem_addr        = $urandom;
        mem_read_enable = 1'b1;
        addr_q.push_back(base_address + (mem_addr * 4));
        n_req++;
      end else begin
        mem_read_enable = 1'b0;
      end
      @(negedge clk);
    end
    mem_read_enable = 1'b0;
    rnd_mode = 1'b0;
    spur_en  = 1'b0;
    drain();
    check("completions", 64'(n_done), 64'(n_req));
    check("final_wait_request", {63'd0, wait_request}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
